ca_item_scheduler: RTL and testbench

- Shares one cellular-automaton item-vector generator among NUM_REQ requesters, e.g. per-channel encoders fetching item hypervectors by index.
- Item k is defined as the CA state after k rule steps from `CELLULAR_AUTOMATON_SEED.
- The block arbitrates requests round-robin and drives the CA enable/clear controls. It tracks the CA step count so it steps forward when possible and clears to seed only when the target index is behind the current state.
- It returns the resulting hypervector with a valid/ready handshake.

---
 rtl/ca_item_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_ca_item_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_item_scheduler.sv
// ca_item_scheduler
// Shares one cellular-automaton item generator among NUM_REQ requesters.
// Item k is the CA state k rule steps after the seed. The block picks one
// pending request round-robin, then moves the CA to the requested item. It
// steps forward when the target is ahead of the CA, and clears to seed first
// when the target is behind it. The CA cells are then returned with a
// valid/ready handshake.
//
// Ports
//   Clk_CI        clock
//   Reset_RI      asynchronous active-high reset (shared with the CA)
//   ReqValid_SI   per-requester request valid
//   ReqIndex_DI   requester r index at [r*INDEX_WIDTH +: INDEX_WIDTH]
//   ReqReady_SO   one-hot accept pulse, asserted in the accept cycle
//   CaEnable_SO   CA step enable
//   CaClear_SO    CA synchronous clear to seed
//   CaCells_DI    current CA cell vector
//   RespValid_SO  response valid
//   RespReady_SI  response consumer ready
//   RespId_DO     ID of the served requester
//   RespHV_DO     item hypervector (CA cells, held stable during RESP)
//   Busy_SO       high whenever the scheduler is not idle

`ifndef HV_DIMENSION
`define HV_DIMENSION 512
`endif

module ca_item_scheduler #(
    parameter int WIDTH       = `HV_DIMENSION,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                           Clk_CI,
    input  logic                           Reset_RI,
    input  logic [NUM_REQ-1:0]             ReqValid_SI,
    input  logic [NUM_REQ*INDEX_WIDTH-1:0] ReqIndex_DI,
    output logic [NUM_REQ-1:0]             ReqReady_SO,
    output logic                           CaEnable_SO,
    output logic                           CaClear_SO,
    input  logic [WIDTH-1:0]               CaCells_DI,
    output logic                           RespValid_SO,
    input  logic                           RespReady_SI,
    output logic [ID_WIDTH-1:0]            RespId_DO,
    output logic [WIDTH-1:0]               RespHV_DO,
    output logic                           Busy_SO
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_STEP  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_n_s;
    logic [INDEX_WIDTH-1:0] step_cnt_r;
    logic [INDEX_WIDTH-1:0] step_cnt_n_s;
    logic [INDEX_WIDTH-1:0] target_r;
    logic [INDEX_WIDTH-1:0] target_n_s;
    logic [ID_WIDTH-1:0]    id_r;
    logic [ID_WIDTH-1:0]    id_n_s;
    logic [ID_WIDTH-1:0]    rr_ptr_r;
    logic [ID_WIDTH-1:0]    rr_ptr_n_s;

    logic                   hi_found_s;
    logic                   lo_found_s;
    logic [ID_WIDTH-1:0]    hi_id_s;
    logic [ID_WIDTH-1:0]    lo_id_s;
    logic                   grant_found_s;
    logic [ID_WIDTH-1:0]    grant_id_s;
    logic [INDEX_WIDTH-1:0] grant_index_s;

    logic [NUM_REQ-1:0]     req_ready_s;
    logic                   ca_enable_s;
    logic                   ca_clear_s;
    logic                   resp_valid_s;

    // Round-robin arbiter: lowest valid requester at or above rr_ptr_r,
    // otherwise lowest valid requester below it (wrap-around). The loop runs
    // downward so the last hit written is the lowest index of each group.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_id_s    = '0;
        lo_id_s    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (ReqValid_SI[i]) begin
                if (i >= int'(rr_ptr_r)) begin
                    hi_found_s = 1'b1;
                    hi_id_s    = ID_WIDTH'(i);
                end else begin
                    lo_found_s = 1'b1;
                    lo_id_s    = ID_WIDTH'(i);
                end
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        grant_found_s = hi_found_s | lo_found_s;
        if (hi_found_s) begin
            grant_id_s = hi_id_s;
        end else begin
            grant_id_s = lo_id_s;
        end
    end

    // Index mux for the granted requester.
    always_comb begin
        grant_index_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_s == ID_WIDTH'(i)) begin
                grant_index_s = ReqIndex_DI[i*INDEX_WIDTH +: INDEX_WIDTH];
            end else begin
                grant_index_s = grant_index_s;
            end
        end
    end

    // Next-state, next-register and output decode.
    always_comb begin
        state_n_s    = state_r;
        step_cnt_n_s = step_cnt_r;
        target_n_s   = target_r;
        id_n_s       = id_r;
        rr_ptr_n_s   = rr_ptr_r;
        req_ready_s  = '0;
        ca_enable_s  = 1'b0;
        ca_clear_s   = 1'b0;
        resp_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Gate with reset so no accept pulse leaks while held in reset.
                if (grant_found_s && !Reset_RI) begin
                    req_ready_s = NUM_REQ'(1'b1) << grant_id_s;
                    target_n_s  = grant_index_s;
                    id_n_s      = grant_id_s;
                    if (grant_index_s == step_cnt_r) begin
                        state_n_s = ST_RESP;
                    end else if (grant_index_s > step_cnt_r) begin
                        state_n_s = ST_STEP;
                    end else begin
                        state_n_s = ST_CLEAR;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ca_clear_s   = 1'b1;
                step_cnt_n_s = '0;
                if (target_r == '0) begin
                    state_n_s = ST_RESP;
                end else begin
                    state_n_s = ST_STEP;
                end
            end
            ST_STEP: begin
                // Only entered with target ahead of the count, so the
                // increment never passes the maximum index.
                ca_enable_s  = 1'b1;
                step_cnt_n_s = step_cnt_r + INDEX_WIDTH'(1);
                if (step_cnt_r + INDEX_WIDTH'(1) == target_r) begin
                    state_n_s = ST_RESP;
                end else begin
                    state_n_s = ST_STEP;
                end
            end
            ST_RESP: begin
                resp_valid_s = 1'b1;
                if (RespReady_SI) begin
                    if (int'(id_r) >= NUM_REQ - 1) begin
                        rr_ptr_n_s = '0;
                    end else begin
                        rr_ptr_n_s = id_r + ID_WIDTH'(1);
                    end
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_RESP;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_r    <= ST_IDLE;
            step_cnt_r <= '0;
            target_r   <= '0;
            id_r       <= '0;
            rr_ptr_r   <= '0;
        end else begin
            state_r    <= state_n_s;
            step_cnt_r <= step_cnt_n_s;
            target_r   <= target_n_s;
            id_r       <= id_n_s;
            rr_ptr_r   <= rr_ptr_n_s;
        end
    end

    assign ReqReady_SO  = req_ready_s;
    assign CaEnable_SO  = ca_enable_s;
    assign CaClear_SO   = ca_clear_s;
    assign RespValid_SO = resp_valid_s;
    // ID and vector are forced to zero outside RESP so every output reads 0
    // in IDLE and under reset.
    assign RespId_DO    = resp_valid_s ? id_r : '0;
    assign RespHV_DO    = resp_valid_s ? CaCells_DI : '0;
    assign Busy_SO      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ca_item_scheduler.sv
module tb_ca_item_scheduler;

    localparam int W  = 32;
    localparam int NR = 4;
    localparam int IW = 6;
    localparam logic [W-1:0] SEED = 32'h0001_0000;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*IW-1:0] req_index;
    logic [NR-1:0]   req_ready;
    logic            ca_en;
    logic            ca_clr;
    logic [W-1:0]    ca_cells;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [W-1:0]    resp_hv;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    ca_item_scheduler #(.WIDTH(W), .NUM_REQ(NR), .ID_WIDTH(2), .INDEX_WIDTH(IW)) dut (
        .Clk_CI(clk), .Reset_RI(rst), .ReqValid_SI(req_valid), .ReqIndex_DI(req_index),
        .ReqReady_SO(req_ready), .CaEnable_SO(ca_en), .CaClear_SO(ca_clr),
        .CaCells_DI(ca_cells), .RespValid_SO(resp_valid), .RespReady_SI(resp_ready),
        .RespId_DO(resp_id), .RespHV_DO(resp_hv), .Busy_SO(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rule 30 on a ring: new[i] = left ^ (centre | right), left = bit i+1.
    function automatic logic [W-1:0] rule30(input logic [W-1:0] c);
        logic [W-1:0] n;
        for (int i = 0; i < W; i++) begin
            n[i] = c[(i + 1) % W] ^ (c[i] | c[(i + W - 1) % W]);
        end
        return n;
    endfunction

    function automatic logic [W-1:0] golden(input int k);
        logic [W-1:0] c;
        c = SEED;
        for (int i = 0; i < k; i++) c = rule30(c);
        return c;
    endfunction

    // CA instance stand-in driven by the scheduler's controls.
    always @(posedge clk or posedge rst) begin
        if (rst)          ca_cells <= SEED;
        else if (ca_clr)  ca_cells <= SEED;
        else if (ca_en)   ca_cells <= rule30(ca_cells);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Upcoming CA control words before the response: bit1 clear, bit0 enable.
    logic [1:0] m_plan[$];
    bit         m_busy   = 1'b0;
    int         m_step   = 0;
    int         m_rr     = 0;
    int         m_id     = 0;
    int         m_target = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_en", ca_en, 0);
            chk("rst_clr", ca_clr, 0);
            chk("rst_valid", resp_valid, 0);
            chk("rst_id", resp_id, 0);
            chk("rst_hv", resp_hv, 0);
            chk("rst_busy", busy, 0);
            m_plan.delete();
            m_busy = 1'b0; m_step = 0; m_rr = 0;
        end else if (!m_busy) begin
            int g;
            logic [NR-1:0] exp_rdy;
            g = -1;
            for (int i = 0; i < NR; i++) begin
                int c;
                c = (m_rr + i) % NR;
                if (g < 0 && req_valid[c]) g = c;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("idle_ready", req_ready, exp_rdy);
            chk("idle_en", ca_en, 0);
            chk("idle_clr", ca_clr, 0);
            chk("idle_valid", resp_valid, 0);
            chk("idle_busy", busy, 0);
            if (g >= 0) begin
                m_id = g;
                m_target = int'(req_index[g*IW +: IW]);
                if (m_target < m_step) begin
                    m_plan.push_back(2'b10);
                    repeat (m_target) m_plan.push_back(2'b01);
                end else begin
                    repeat (m_target - m_step) m_plan.push_back(2'b01);
                end
                m_step = m_target;
                m_busy = 1'b1;
            end
        end else if (m_plan.size() > 0) begin
            logic [1:0] w;
            w = m_plan.pop_front();
            chk("work_ready", req_ready, 0);
            chk("work_en", ca_en, w[0]);
            chk("work_clr", ca_clr, w[1]);
            chk("work_valid", resp_valid, 0);
            chk("work_busy", busy, 1);
        end else begin
            chk("resp_valid", resp_valid, 1);
            chk("resp_id", resp_id, m_id);
            chk("resp_hv", resp_hv, golden(m_target));
            chk("resp_en", ca_en, 0);
            chk("resp_clr", ca_clr, 0);
            chk("resp_ready_out", req_ready, 0);
            chk("resp_busy", busy, 1);
            if (resp_ready) begin
                m_busy = 1'b0;
                m_rr = (m_id + 1) % NR;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic take(output int g, output int lat, output int en, output int clr,
                        output logic [W-1:0] hv, output int id);
        int n;
        g = -1; lat = 0; en = 0; clr = 0; hv = '0; id = -1; n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", (n < 100), 1);
        if (n >= 100) return;
        for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
        @(posedge clk); #1 req_valid[g] = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            en += int'(ca_en);
            clr += int'(ca_clr);
            @(negedge clk);
            lat++;
        end
        chk("resp_in_time", (lat < 200), 1);
        hv = resp_hv;
        id = int'(resp_id);
    endtask

    task automatic check_take(input int e_g, input int e_lat, input int e_en, input int e_clr,
                              input logic [W-1:0] e_hv);
        int g, lat, en, clr, id;
        logic [W-1:0] hv;
        take(g, lat, en, clr, hv, id);
        chk("dir_grant", g, e_g);
        chk("dir_latency", lat, e_lat);
        chk("dir_enables", en, e_en);
        chk("dir_clears", clr, e_clr);
        chk("dir_hv", hv, e_hv);
        chk("dir_id", id, e_g);
    endtask

    task automatic serve(input int r, input int idx, input int e_lat, input int e_en,
                         input int e_clr, input logic [W-1:0] e_hv);
        @(posedge clk); #1;
        req_valid[r] = 1'b1;
        req_index[r*IW +: IW] = IW'(idx);
        check_take(r, e_lat, e_en, e_clr, e_hv);
    endtask

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] pin [6];
        logic [W-1:0] hv0;
        logic [NR-1:0] rdy;
        int n;
        pin[0] = 32'h0001_0000; pin[1] = 32'h0003_8000; pin[2] = 32'h0006_4000;
        pin[3] = 32'h000D_E000; pin[4] = 32'h0019_1000; pin[5] = 32'h0037_B800;

        rst = 1'b1; req_valid = '0; req_index = '0; resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) chk("golden_pin", golden(k), pin[k]);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        // Hit, forward step, clear, forward step.
        serve(0, 0, 1, 0, 0, pin[0]);
        serve(1, 5, 6, 5, 0, pin[5]);
        serve(2, 3, 5, 3, 1, pin[3]);
        serve(3, 4, 2, 1, 0, pin[4]);

        // All four requesters with index 2: order 0,1,2,3.
        @(posedge clk); #1;
        req_valid = 4'b1111;
        for (int r = 0; r < NR; r++) req_index[r*IW +: IW] = 6'd2;
        check_take(0, 4, 2, 1, pin[2]);
        check_take(1, 1, 0, 0, pin[2]);
        check_take(2, 1, 0, 0, pin[2]);
        check_take(3, 1, 0, 0, pin[2]);

        // r1 and r3 together after r3's serve: r1 first.
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_index[1*IW +: IW] = 6'd7;
        req_valid[3] = 1'b1; req_index[3*IW +: IW] = 6'd2;
        check_take(1, 6, 5, 0, golden(7));
        check_take(3, 4, 2, 1, pin[2]);

        // Response held for 10 cycles with another request pending.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid[0] = 1'b1; req_index[0*IW +: IW] = 6'd2;
        req_valid[1] = 1'b1; req_index[1*IW +: IW] = 6'd3;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
        chk("hold_accept", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("hold_first_valid", resp_valid, 1);
        hv0 = resp_hv;
        chk("hold_hv", hv0, pin[2]);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_hv_stable", resp_hv, hv0);
            chk("hold_no_ctrl", {ca_en, ca_clr}, 2'b00);
            chk("hold_no_grant", req_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        check_take(1, 2, 1, 0, pin[3]);

        // Reset during STEP for index 9: outputs drop at once, no response.
        @(posedge clk); #1;
        req_valid[2] = 1'b1; req_index[2*IW +: IW] = 6'd9;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
        chk("rst_test_accept", req_ready, 4'b0100);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_test_stepping", ca_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_en", ca_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", resp_valid, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("after_rst_no_resp", resp_valid, 0);
        end
        serve(0, 2, 3, 2, 0, pin[2]);

        // Randomized traffic checked by the model every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #1 rdy = req_ready;
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            for (int r = 0; r < NR; r++) begin
                if (rdy[r]) begin
                    req_valid[r] = 1'b0;
                end else if (!req_valid[r] && $urandom_range(0, 3) == 0) begin
                    req_valid[r] = 1'b1;
                    if ($urandom_range(0, 1) == 1) req_index[r*IW +: IW] = IW'($urandom_range(0, 63));
                    else                          req_index[r*IW +: IW] = IW'($urandom_range(0, 4));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
